sad_match_tracker: RTL

- Downstream consumer of the line buffer stage.
- Takes the 4000-bit window (TPL_H rows × TPL_W bits) the buffer presents each cycle and XORs it with a stored 1-bit template.
- Counts mismatches (binary SAD) in a 2-stage pipeline.
- Tracks the minimum SAD and its window origin over one frame, then reports the best match to the control/readout logic.

---
 rtl/sad_match_tracker.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sad_match_tracker.sv
// sad_match_tracker: binary-SAD template matcher fed by the line buffer window.
// Scores each window origin in a 2-stage pipeline, then tracks the frame's best
// (minimum SAD) match and its origin.
// Optional build macro MATCH_THRESH_EN adds a thresh input and a sticky hit output.
module sad_match_tracker #(
   parameter int unsigned TPL_W    = 40,
   parameter int unsigned TPL_H    = 100,
   parameter int unsigned IMG_W    = 640,
   parameter int unsigned IMG_H    = 480,
   parameter int unsigned FILL_LEN = 307200
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic                     sof,
   input  logic [TPL_W*TPL_H-1:0]   win,
   input  logic [TPL_W*TPL_H-1:0]   tpl,
`ifdef MATCH_THRESH_EN
   input  logic [11:0]              thresh,
   output logic                     hit,
`endif
   output logic [11:0]              sad,
   output logic                     sad_valid,
   output logic [11:0]              best_sad,
   output logic [9:0]               best_x,
   output logic [8:0]               best_y,
   output logic                     done
);

   localparam int unsigned FILL_W = $clog2(FILL_LEN + 1);
   localparam int unsigned ROW_W  = $clog2(TPL_W + 1);
   localparam int unsigned X_MAX  = IMG_W - TPL_W;
   localparam int unsigned Y_MAX  = IMG_H - TPL_H;
   localparam int unsigned X_LAST = IMG_W - 1;
   localparam int unsigned Y_LAST = IMG_H - 1;

   logic [FILL_W-1:0] fill_q, fill_d;
   logic [9:0]        ox_q, ox_d;
   logic [8:0]        oy_q, oy_d;

   logic              s1_vld_q, s1_vld_d;
   logic [9:0]        s1_x_q, s1_x_d;
   logic [8:0]        s1_y_q, s1_y_d;
   logic [ROW_W-1:0]  row_cnt_q [TPL_H];
   logic [ROW_W-1:0]  row_cnt_d [TPL_H];

   logic              sad_vld_q, sad_vld_d;
   logic [11:0]       sad_q, sad_d;
   logic [9:0]        s2_x_q, s2_x_d;
   logic [8:0]        s2_y_q, s2_y_d;

   logic [11:0]       best_sad_q, best_sad_d;
   logic [9:0]        best_x_q, best_x_d;
   logic [8:0]        best_y_q, best_y_d;
   logic              done_q, done_d;

   logic              tracking_c;
   logic              at_end_c;
   logic              launch_c;
   logic [11:0]       sum_c;

   function automatic logic [ROW_W-1:0] popcnt(input logic [TPL_W-1:0] v);
      logic [ROW_W-1:0] c;
      c = '0;
      for (int i = 0; i < TPL_W; i++) c = c + ROW_W'(v[i]);
      return c;
   endfunction

   // Launch qualification: fill complete and origin inside the scorable area
   always_comb begin
      tracking_c = (fill_q == FILL_W'(FILL_LEN));
      at_end_c   = (ox_q == 10'(X_LAST)) && (oy_q == 9'(Y_LAST));
      launch_c   = ena && !sof && tracking_c &&
                   (ox_q <= 10'(X_MAX)) && (oy_q <= 9'(Y_MAX));
   end

   // Fill counter and origin counters
   always_comb begin
      fill_d = fill_q;
      ox_d   = ox_q;
      oy_d   = oy_q;
      if (sof) begin
         fill_d = '0;
         ox_d   = '0;
         oy_d   = '0;
      end else if (ena) begin
         if (!tracking_c) begin
            fill_d = fill_q + FILL_W'(1);
         end else if (!at_end_c) begin
            if (ox_q == 10'(X_LAST)) begin
               ox_d = '0;
               oy_d = oy_q + 9'd1;
            end else begin
               ox_d = ox_q + 10'd1;
            end
         end
      end
   end

   // Stage 1: per-row mismatch popcounts and origin capture
   always_comb begin
      s1_vld_d = launch_c;
      s1_x_d   = s1_x_q;
      s1_y_d   = s1_y_q;
      for (int r = 0; r < TPL_H; r++) row_cnt_d[r] = row_cnt_q[r];
      if (launch_c) begin
         s1_x_d = ox_q;
         s1_y_d = oy_q;
         for (int r = 0; r < TPL_H; r++)
            row_cnt_d[r] = popcnt(win[r*TPL_W +: TPL_W] ^ tpl[r*TPL_W +: TPL_W]);
      end
   end

   // Stage 2: adder tree over row counts
   always_comb begin
      sum_c = '0;
      for (int r = 0; r < TPL_H; r++) sum_c = sum_c + 12'(row_cnt_q[r]);
      sad_vld_d = s1_vld_q && !sof;
      sad_d     = sad_q;
      s2_x_d    = s2_x_q;
      s2_y_d    = s2_y_q;
      if (s1_vld_q && !sof) begin
         sad_d  = sum_c;
         s2_x_d = s1_x_q;
         s2_y_d = s1_y_q;
      end
   end

   // Stage 3: strict-less best tracking; ties keep the earlier origin
   always_comb begin
      best_sad_d = best_sad_q;
      best_x_d   = best_x_q;
      best_y_d   = best_y_q;
      done_d     = done_q;
      if (sof) begin
         best_sad_d = 12'hFFF;
         done_d     = 1'b0;
      end else if (sad_vld_q && !done_q) begin
         if (sad_q < best_sad_q) begin
            best_sad_d = sad_q;
            best_x_d   = s2_x_q;
            best_y_d   = s2_y_q;
         end
         if ((s2_x_q == 10'(X_MAX)) && (s2_y_q == 9'(Y_MAX))) done_d = 1'b1;
      end
   end

   // Pipeline and tracking state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_q     <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         s1_vld_q   <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         for (int r = 0; r < TPL_H; r++) row_cnt_q[r] <= '0;
         sad_vld_q  <= 1'b0;
         sad_q      <= '0;
         s2_x_q     <= '0;
         s2_y_q     <= '0;
         best_sad_q <= 12'hFFF;
         best_x_q   <= '0;
         best_y_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         fill_q     <= fill_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         s1_vld_q   <= s1_vld_d;
         s1_x_q     <= s1_x_d;
         s1_y_q     <= s1_y_d;
         for (int r = 0; r < TPL_H; r++) row_cnt_q[r] <= row_cnt_d[r];
         sad_vld_q  <= sad_vld_d;
         sad_q      <= sad_d;
         s2_x_q     <= s2_x_d;
         s2_y_q     <= s2_y_d;
         best_sad_q <= best_sad_d;
         best_x_q   <= best_x_d;
         best_y_q   <= best_y_d;
         done_q     <= done_d;
      end
   end

`ifdef MATCH_THRESH_EN
   logic hit_q, hit_d;

   // Sticky threshold hit on any scored window
   always_comb begin
      hit_d = hit_q;
      if (sof)                                 hit_d = 1'b0;
      else if (sad_vld_q && (sad_q <= thresh)) hit_d = 1'b1;
   end

   // Hit flag register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) hit_q <= 1'b0;
      else      hit_q <= hit_d;
   end

   assign hit = hit_q;
`endif

   assign sad       = sad_q;
   assign sad_valid = sad_vld_q;
   assign best_sad  = best_sad_q;
   assign best_x    = best_x_q;
   assign best_y    = best_y_q;
   assign done      = done_q;

endmodule
